// File: rtl/mem_arbiter_if.sv
`default_nettype none
// mem_arbiter_if: fetch port, data port and memory port of the IF/MEM memory arbiter.
// The slave modport is the arbiter; the master modport is the pipeline plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata, d_err,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata, d_err,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one single-port synchronous memory between instruction fetch and load/store.
// Optional misaligned-data check enabled by defining MEM_ARB_MISALIGN_CHK_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_FULL = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic              own_d_q;
  logic              mis_q;
  logic              st_q;
  logic [LAT_W-1:0]  lat_q;
  logic [STV_W-1:0]  starve_q;
  logic              if_valid_q;
  logic [31:0]       if_rdata_q;
  logic              d_valid_q;
  logic [31:0]       d_rdata_q;
  logic              d_err_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic grant_if;
  logic mis_chk;

  assign grant_if = bus.if_req && (!bus.d_req || (starve_q == STV_FULL));

`ifdef MEM_ARB_MISALIGN_CHK_EN
  assign mis_chk = ((bus.d_size == 2'b01) && bus.d_addr[0]) ||
                   ((bus.d_size == 2'b10) && (bus.d_addr[1:0] != 2'b00));
`else
  assign mis_chk = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      own_d_q     <= 1'b0;
      mis_q       <= 1'b0;
      st_q        <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_if) begin
            own_d_q    <= 1'b0;
            mis_q      <= 1'b0;
            st_q       <= 1'b0;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_size_q <= 2'b10;
            mem_addr_q <= bus.if_addr;
            starve_q   <= '0;
            state_q    <= S_ACCESS;
          end else if (bus.d_req) begin
            own_d_q <= 1'b1;
            mis_q   <= mis_chk;
            st_q    <= bus.d_we;
            // A misaligned access keeps its slot timing but never touches memory.
            if (!mis_chk) begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_size_q  <= bus.d_size;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end
            if (bus.if_req && (starve_q != STV_FULL)) begin
              starve_q <= starve_q + STV_W'(1);
            end
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_we_q <= 1'b0;
          lat_q    <= LAT_W'(1);
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // mem_rdata is valid now, MEM_LAT cycles after the strobe.
          if (lat_q == LAT_LAST) begin
            if (own_d_q) begin
              d_valid_q <= 1'b1;
              d_err_q   <= mis_q;
              if (mis_q) begin
                d_rdata_q <= '0;
              end else if (!st_q) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
            state_q <= S_RESP;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: random fetch/load/store traffic checked against a transaction-timing model,
// plus directed MEM_LAT=3 load checks on a second instance.
module tb_mem_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int STV  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8)) b1 ();
  mem_arbiter_if #(.ADDR_W(8)) b3 ();

  mem_arbiter #(.ADDR_W(8), .MEM_LAT(LAT), .STARVE_MAX(STV)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  mem_arbiter #(.ADDR_W(8), .MEM_LAT(LAT3), .STARVE_MAX(STV)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] lat3_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic bit mis_of(input logic [1:0] sz, input logic [7:0] a);
`ifdef MEM_ARB_MISALIGN_CHK_EN
    return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
`else
    return (sz == 2'b11) && (a == 8'hFF) && 1'b0;
`endif
  endfunction

  // Environment memory for the MEM_LAT=1 instance: reads return data LAT cycles after mem_en.
  logic [31:0] mem_a  [256];
  logic [31:0] pipe_a [LAT];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else if (b1.mem_en && b1.mem_we) begin
      mem_a[b1.mem_addr] <= b1.mem_wdata;
    end
    pipe_a[0] <= (b1.mem_en && !b1.mem_we) ? mem_a[b1.mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign b1.mem_rdata = pipe_a[LAT-1];

  logic [31:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe3[0] <= b3.mem_en ? lat3_word(b3.mem_addr) : $urandom;
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign b3.mem_rdata = pipe3[LAT3-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lat3_load(input logic [7:0] a, input string tag);
    bit          e_mis;
    logic [31:0] e_data;
    e_mis  = mis_of(2'b10, a);
    e_data = e_mis ? 32'h0 : lat3_word(a);
    @(negedge clk);
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_size = 2'b10; b3.d_addr = a; b3.d_wdata = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) b3.d_req = 1'b0;
      #1;
      chk({tag, "_mem_en"},  {31'b0, b3.mem_en},  {31'b0, (c == 1) && !e_mis});
      chk({tag, "_d_valid"}, {31'b0, b3.d_valid}, {31'b0, c == 5});
      chk({tag, "_d_err"},   {31'b0, b3.d_err},   {31'b0, (c == 5) && e_mis});
      if ((c == 1) && !e_mis) chk({tag, "_mem_addr"}, {24'b0, b3.mem_addr}, {24'b0, a});
      if (c >= 5) chk({tag, "_d_rdata"}, b3.d_rdata, e_data);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] exp_mem [256];
    logic [31:0] last_fetch, last_load, m_wdata;
    logic [7:0]  m_addr;
    logic [1:0]  m_size;
    bit          act, own_d, mis, st, if_done, d_done, rst_done;
    bit          e_en, e_ifv, e_dv, e_err;
    int          en_c, val_c, starve, p_start, p_keep;

    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_size = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_size = 0; b3.d_addr = 0; b3.d_wdata = 0;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("rst_mem_en",   {31'b0, b1.mem_en},   32'h0);
    chk("rst_if_valid", {31'b0, b1.if_valid}, 32'h0);
    chk("rst_d_valid",  {31'b0, b1.d_valid},  32'h0);
    chk("rst_if_rdata", b1.if_rdata, 32'h0);
    chk("rst_d_rdata",  b1.d_rdata,  32'h0);
    chk("rst_mem_addr", {24'b0, b1.mem_addr}, 32'h0);
    mem_init = 1'b0;
    rst = 1'b1;

    act = 0; own_d = 0; mis = 0; st = 0; starve = 0; en_c = -1; val_c = -1;
    last_fetch = 0; last_load = 0; if_done = 0; d_done = 0; rst_done = 0;
    m_addr = 0; m_size = 0; m_wdata = 0;

    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      p_start = (t < 400) ? 100 : 40;
      p_keep  = (t < 400) ? 100 : 30;
      if (rst == 1'b0) begin
        rst = 1'b1;
        b1.if_req = 1'b0;
        b1.d_req  = 1'b0;
      end else begin
        if (!(b1.if_req && !if_done)) begin
          if ($urandom_range(99) < (b1.if_req ? p_keep : p_start)) begin
            b1.if_req  = 1'b1;
            b1.if_addr = 8'($urandom);
          end else begin
            b1.if_req = 1'b0;
          end
        end
        if (!(b1.d_req && !d_done)) begin
          if ($urandom_range(99) < (b1.d_req ? p_keep : p_start)) begin
            b1.d_req   = 1'b1;
            b1.d_we    = 1'($urandom_range(1));
            b1.d_size  = 2'($urandom_range(2));
            b1.d_addr  = 8'($urandom);
            b1.d_wdata = $urandom;
          end else begin
            b1.d_req = 1'b0;
          end
        end
      end
      if_done = 0;
      d_done  = 0;
      #1;

      // Grant: data first unless the fetch side has been passed over STV times.
      if (!act && (b1.if_req || b1.d_req)) begin
        act   = 1;
        en_c  = t + 1;
        val_c = t + LAT + 2;
        if (b1.if_req && (!b1.d_req || starve == STV)) begin
          own_d = 0; mis = 0; st = 0; m_addr = b1.if_addr; m_size = 2'b10; starve = 0;
        end else begin
          own_d = 1; st = b1.d_we; m_addr = b1.d_addr; m_size = b1.d_size; m_wdata = b1.d_wdata;
          mis = mis_of(b1.d_size, b1.d_addr);
          if (b1.if_req && starve < STV) starve++;
        end
      end

      e_en  = act && (t == en_c) && !mis;
      e_ifv = act && (t == val_c) && !own_d;
      e_dv  = act && (t == val_c) && own_d;
      e_err = e_dv && mis;
      if (e_ifv) last_fetch = exp_mem[m_addr];
      if (e_dv) begin
        if (mis) last_load = 32'h0;
        else if (!st) last_load = exp_mem[m_addr];
        else exp_mem[m_addr] = m_wdata;
      end

      chk("mem_en",    {31'b0, b1.mem_en},    {31'b0, e_en});
      chk("if_valid",  {31'b0, b1.if_valid},  {31'b0, e_ifv});
      chk("d_valid",   {31'b0, b1.d_valid},   {31'b0, e_dv});
      chk("d_err",     {31'b0, b1.d_err},     {31'b0, e_err});
      chk("if_rdata",  b1.if_rdata, last_fetch);
      chk("d_rdata",   b1.d_rdata,  last_load);
      chk("stall_if",  {31'b0, b1.stall_if},  {31'b0, b1.if_req && !e_ifv});
      chk("stall_mem", {31'b0, b1.stall_mem}, {31'b0, b1.d_req && !e_dv});
      if (e_en) begin
        chk("mem_addr", {24'b0, b1.mem_addr}, {24'b0, m_addr});
        chk("mem_we",   {31'b0, b1.mem_we},   {31'b0, st});
        chk("mem_size", {30'b0, b1.mem_size}, {30'b0, m_size});
        if (st) chk("mem_wdata", b1.mem_wdata, m_wdata);
      end else begin
        chk("mem_we_idle", {31'b0, b1.mem_we}, 32'h0);
      end

      if (act && (t == val_c)) begin
        act = 0;
        if (own_d) d_done = 1;
        else if_done = 1;
      end

      // Asynchronous reset in the middle of an access cycle abandons it.
      if (!rst_done && (t >= 700) && act && (t == en_c)) begin
        rst = 1'b0;
        #1;
        chk("arst_mem_en",   {31'b0, b1.mem_en},   32'h0);
        chk("arst_if_valid", {31'b0, b1.if_valid}, 32'h0);
        chk("arst_d_valid",  {31'b0, b1.d_valid},  32'h0);
        chk("arst_if_rdata", b1.if_rdata, 32'h0);
        chk("arst_d_rdata",  b1.d_rdata,  32'h0);
        act = 0; starve = 0; last_fetch = 0; last_load = 0;
        if_done = 0; d_done = 0; rst_done = 1;
      end
    end
    b1.if_req = 1'b0;
    b1.d_req  = 1'b0;
    chk("reset_injected", {31'b0, rst_done}, 32'h1);

    lat3_load(8'h20, "lat3_word");
    lat3_load(8'h06, "lat3_mis");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
